// File: rtl/hbridge_pwm_decoder.sv
// hbridge_pwm_decoder
// Watches the H-bridge drive pins (ena PWM, in1, in2) and recovers the
// measured duty, direction and a shoot-through style fault flag. The pins
// are synchronized, sampled on a prescaled tick, and summarized once per
// frame of FRAME ticks with a one-clock duty_valid strobe.
//
// Optional feature macro: HBRIDGE_DECODER_PCT_EN
//   defined   -> duty_pct = floor(hi_cnt*100 / FRAME), registered on report
//   undefined -> no multiplier, duty_pct tied to 0
module hbridge_pwm_decoder #(
  parameter int DIV   = 1200,  // clk cycles per sample tick, >= 2
  parameter int FRAME = 256    // sample ticks per frame, power of two 16..256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       in1,
  input  logic       in2,
  output logic [7:0] duty,
  output logic [1:0] dir,
  output logic       fault,
  output logic       duty_valid,
  output logic [6:0] duty_pct
);

  localparam int DIVW = $clog2(DIV);
  localparam int CW   = $clog2(FRAME);

  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(DIV - 1);
  localparam logic [CW-1:0]   FRAME_LAST = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    ALIGN   = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Pin synchronizers: bit 0 = ena, bit 1 = in1, bit 2 = in2
  // ------------------------------------------------------------------
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       ena_prev_q;

  logic ena_s;
  logic in1_s;
  logic in2_s;
  logic ena_rise;

  // Two-flop synchronizer on every bridge pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {in2, in1, ena};
      sync_q <= meta_q;
    end
  end

  assign ena_s = sync_q[0];
  assign in1_s = sync_q[1];
  assign in2_s = sync_q[2];

  // Delayed synchronized ena, used to find the PWM rising edge for alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_prev_q <= 1'b0;
    end else begin
      ena_prev_q <= ena_s;
    end
  end

  assign ena_rise = ena_s & ~ena_prev_q;

  // ------------------------------------------------------------------
  // Prescaler: free-running, tick on the last count of each period
  // ------------------------------------------------------------------
  logic [DIVW-1:0] div_cnt_q;
  logic            tick;

  assign tick = (div_cnt_q == DIV_LAST);

  // Prescaler counter wrapping 0..DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIVW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Frame state, accumulators and registered outputs
  // ------------------------------------------------------------------
  state_t        state_q,      state_d;
  logic [CW-1:0] align_cnt_q,  align_cnt_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [8:0]    hi_cnt_q,     hi_cnt_d;
  logic [1:0]    dir_acc_q,    dir_acc_d;
  logic          flt_acc_q,    flt_acc_d;

  logic [7:0]    duty_q,       duty_d;
  logic [1:0]    dir_q,        dir_d;
  logic          fault_q,      fault_d;
  logic          valid_q,      valid_d;

  // Accumulator values after folding in the current synchronized sample
  logic [8:0]    hi_upd;
  logic [1:0]    dir_upd;
  logic          flt_upd;
  logic          report_now;

  // Fold one sample into the accumulators (only meaningful on a tick)
  always_comb begin
    hi_upd  = hi_cnt_q;
    dir_upd = dir_acc_q;
    flt_upd = flt_acc_q;
    if (ena_s) begin
      hi_upd = hi_cnt_q + 9'd1;
      if (in1_s != in2_s) begin
        dir_upd = {in2_s, in1_s};
      end else begin
        flt_upd = 1'b1;
      end
    end
  end

  // Next-state logic for alignment, measurement and reporting
  always_comb begin
    state_d      = state_q;
    align_cnt_d  = align_cnt_q;
    sample_cnt_d = sample_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    dir_acc_d    = dir_acc_q;
    flt_acc_d    = flt_acc_q;
    duty_d       = duty_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    valid_d      = 1'b0;
    report_now   = 1'b0;

    case (state_q)
      ALIGN: begin
        if (ena_rise) begin
          // The tick closing the edge's period is sample 0; if the tick
          // lands on the edge cycle itself that sample is taken right now.
          state_d     = MEASURE;
          align_cnt_d = '0;
          if (tick) begin
            sample_cnt_d = CW'(1);
            hi_cnt_d     = hi_upd;
            dir_acc_d    = dir_upd;
            flt_acc_d    = flt_upd;
          end else begin
            sample_cnt_d = '0;
          end
        end else if (tick) begin
          if (align_cnt_q == FRAME_LAST) begin
            // No PWM edge within a whole frame: start measuring anyway
            state_d      = MEASURE;
            align_cnt_d  = '0;
            sample_cnt_d = '0;
          end else begin
            align_cnt_d = align_cnt_q + CW'(1);
          end
        end
      end

      MEASURE: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
          hi_cnt_d     = hi_upd;
          dir_acc_d    = dir_upd;
          flt_acc_d    = flt_upd;
          if (sample_cnt_q == FRAME_LAST) begin
            // Last sample of the frame: publish so the strobe is high
            // exactly during the REPORT cycle.
            state_d    = REPORT;
            report_now = 1'b1;
            duty_d     = hi_upd[8] ? 8'hFF : hi_upd[7:0];
            dir_d      = dir_upd;
            fault_d    = flt_upd;
            valid_d    = 1'b1;
          end
        end
      end

      REPORT: begin
        // Prescaler cannot tick here (DIV >= 2), so nothing is lost
        state_d      = MEASURE;
        sample_cnt_d = '0;
        hi_cnt_d     = '0;
        dir_acc_d    = 2'b00;
        flt_acc_d    = 1'b0;
      end

      default: begin
        state_d = ALIGN;
      end
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ALIGN;
      align_cnt_q  <= '0;
      sample_cnt_q <= '0;
      hi_cnt_q     <= '0;
      dir_acc_q    <= 2'b00;
      flt_acc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      align_cnt_q  <= align_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      dir_acc_q    <= dir_acc_d;
      flt_acc_q    <= flt_acc_d;
    end
  end

  // Output registers, held between reports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= 8'd0;
      dir_q   <= 2'b00;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
      valid_q <= valid_d;
    end
  end

  assign duty       = duty_q;
  assign dir        = dir_q;
  assign fault      = fault_q;
  assign duty_valid = valid_q;

`ifdef HBRIDGE_DECODER_PCT_EN
  // Percent = hi_cnt*100 / FRAME; FRAME is a power of two so the divide
  // is a right shift. 256*100 fits comfortably in 16 bits.
  logic [15:0] pct_prod;
  logic [6:0]  pct_w;
  logic [6:0]  pct_q, pct_d;

  assign pct_prod = {7'd0, hi_upd} * 16'd100;
  assign pct_w    = 7'(pct_prod >> CW);

  // Capture the percentage alongside the other report fields
  always_comb begin
    pct_d = pct_q;
    if (report_now) begin
      pct_d = pct_w;
    end
  end

  // Percent output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pct_q <= 7'd0;
    end else begin
      pct_q <= pct_d;
    end
  end

  assign duty_pct = pct_q;
`else
  assign duty_pct = 7'd0;
`endif

endmodule

// File: tb/tb_hbridge_pwm_decoder.sv
// Scoreboard bench for hbridge_pwm_decoder. Two instances: the main one at
// DIV=4/FRAME=256 and a small one at DIV=2/FRAME=16. Stimulus pushes the
// expected report into a queue; a per-instance monitor pops on duty_valid.
module tb_hbridge_pwm_decoder;

`ifdef HBRIDGE_DECODER_PCT_EN
  localparam bit PCT_ON = 1'b1;
`else
  localparam bit PCT_ON = 1'b0;
`endif

  typedef struct {
    int duty;
    int dir;
    int fault;
    int pct;
    int gap;   // expected clk count, 0 = not checked
    bit rel;   // 1: gap measured from reset release, 0: from previous strobe
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena_a = 1'b0, in1_a = 1'b0, in2_a = 1'b0;
  logic [7:0] duty_a;
  logic [1:0] dir_a;
  logic       fault_a, valid_a;
  logic [6:0] pct_a;

  logic rst2 = 1'b0;
  logic ena_b = 1'b0, in1_b = 1'b0, in2_b = 1'b0;
  logic [7:0] duty_b;
  logic [1:0] dir_b;
  logic       fault_b, valid_b;
  logic [6:0] pct_b;

  int total = 0;
  int bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int since_a = 0, since_b = 0;
  int last_since_a = 0, last_since_b = 0;
  int strobes_a = 0, strobes_b = 0;

  always #5 clk = ~clk;

  hbridge_pwm_decoder #(.DIV(4), .FRAME(256)) u_dut (
    .clk(clk), .rst(rst), .ena(ena_a), .in1(in1_a), .in2(in2_a),
    .duty(duty_a), .dir(dir_a), .fault(fault_a),
    .duty_valid(valid_a), .duty_pct(pct_a)
  );

  hbridge_pwm_decoder #(.DIV(2), .FRAME(16)) u_small (
    .clk(clk), .rst(rst2), .ena(ena_b), .in1(in1_b), .in2(in2_b),
    .duty(duty_b), .dir(dir_b), .fault(fault_b),
    .duty_valid(valid_b), .duty_pct(pct_b)
  );

  // Clock counts since the most recent reset release
  always @(posedge clk or posedge rst) begin
    if (rst) since_a <= 0;
    else     since_a <= since_a + 1;
  end
  always @(posedge clk or posedge rst2) begin
    if (rst2) since_b <= 0;
    else      since_b <= since_b + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int d, input int dr, input int f,
                              input int p, input int gap, input bit rel);
    exp_t e;
    e.duty = d; e.dir = dr; e.fault = f;
    e.pct = PCT_ON ? p : 0;
    e.gap = gap; e.rel = rel;
    return e;
  endfunction

  // Monitor for the main instance
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (valid_a) begin
      $display("A report @%0d: duty=%0d dir=%0d fault=%0d pct=%0d",
               since_a, duty_a, dir_a, fault_a, pct_a);
      if (q_a.size() == 0) begin
        chk("a_unexpected_strobe", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_duty", int'(duty_a), e.duty);
        chk("a_dir", int'(dir_a), e.dir);
        chk("a_fault", int'(fault_a), e.fault);
        chk("a_pct", int'(pct_a), e.pct);
        if (e.gap > 0)
          chk("a_gap", e.rel ? since_a : since_a - last_since_a, e.gap);
      end
      last_since_a = since_a;
      strobes_a++;
    end
  end

  // Monitor for the small instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (valid_b) begin
      $display("B report @%0d: duty=%0d dir=%0d fault=%0d pct=%0d",
               since_b, duty_b, dir_b, fault_b, pct_b);
      if (q_b.size() == 0) begin
        chk("b_unexpected_strobe", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_duty", int'(duty_b), e.duty);
        chk("b_dir", int'(dir_b), e.dir);
        chk("b_fault", int'(fault_b), e.fault);
        chk("b_pct", int'(pct_b), e.pct);
        if (e.gap > 0)
          chk("b_gap", e.rel ? since_b : since_b - last_since_b, e.gap);
      end
      last_since_b = since_b;
      strobes_b++;
    end
  end

  // Reset the main instance with the given pin levels, release mid-cycle
  task automatic start_a(input logic e, input logic i1, input logic i2);
    @(negedge clk);
    #1 rst = 1'b1;
    ena_a = e; in1_a = i1; in2_a = i2;
    #2 rst = 1'b0;
  endtask

  task automatic drain_a(input string name, input int budget);
    int n = 0;
    while (q_a.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, q_a.size(), 0);
  endtask

  task automatic drain_b(input string name, input int budget);
    int n = 0;
    while (q_b.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, q_b.size(), 0);
  endtask

  task automatic pwm_a(input int periods, input int hi, input int lo);
    for (int p = 0; p < periods; p++) begin
      ena_a = 1'b1;
      repeat (hi) @(posedge clk);
      #1 ena_a = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_b(input int periods, input int hi, input int lo);
    for (int p = 0; p < periods; p++) begin
      ena_b = 1'b1;
      repeat (hi) @(posedge clk);
      #1 ena_b = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int s0;
    #1 rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", int'(duty_a), 0);
    chk("rst_dir", int'(dir_a), 0);
    chk("rst_fault", int'(fault_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_pct", int'(pct_a), 0);

    // 1: ena idle -> ALIGN timeout then one frame
    q_a.push_back(mk(0, 0, 0, 0, 2048, 1'b1));
    start_a(1'b0, 1'b1, 1'b0);
    drain_a("t1_drain", 2200);

    // 2: 64/256 PWM forward
    q_a.push_back(mk(64, 1, 0, 25, 1024, 1'b1));
    q_a.push_back(mk(64, 1, 0, 25, 1024, 1'b0));
    start_a(1'b1, 1'b1, 1'b0);
    pwm_a(2, 256, 768);
    drain_a("t2_drain", 200);

    // 3: ena constant high, reverse, saturation and strobe spacing
    q_a.push_back(mk(255, 2, 0, 100, 1024, 1'b1));
    q_a.push_back(mk(255, 2, 0, 100, 1024, 1'b0));
    start_a(1'b1, 1'b0, 1'b1);
    drain_a("t3_drain", 2200);

    // 4: one faulty sample then clean forward
    q_a.push_back(mk(255, 1, 1, 100, 1024, 1'b1));
    q_a.push_back(mk(255, 1, 0, 100, 1024, 1'b0));
    start_a(1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1 in2_a = 1'b0;
    drain_a("t4_drain", 2200);

    // 5: asynchronous reset pulse mid-MEASURE
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_duty", int'(duty_a), 255);
    #1 rst = 1'b1;
    #1;
    chk("t5_duty", int'(duty_a), 0);
    chk("t5_dir", int'(dir_a), 0);
    chk("t5_fault", int'(fault_a), 0);
    chk("t5_valid", int'(valid_a), 0);
    chk("t5_pct", int'(pct_a), 0);
    #1 rst = 1'b0;
    s0 = strobes_a;
    repeat (1020) @(posedge clk);
    #1 chk("t5_quiet", strobes_a - s0, 0);
    q_a.push_back(mk(255, 1, 0, 100, 1024, 1'b1));
    drain_a("t5_drain", 200);

    // 6: small instance, 50% PWM
    q_b.push_back(mk(8, 1, 0, 50, 0, 1'b1));
    q_b.push_back(mk(8, 1, 0, 50, 32, 1'b0));
    q_b.push_back(mk(8, 1, 0, 50, 32, 1'b0));
    @(negedge clk);
    #1 ena_b = 1'b1; in1_b = 1'b1; in2_b = 1'b0;
    #2 rst2 = 1'b0;
    pwm_b(4, 16, 16);
    drain_b("t6_drain", 100);
    rst2 = 1'b1;
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hbridge_pwm_decoder.md
Name: hbridge_pwm_decoder

Overview:
- Monitors the H-bridge drive outputs (ena PWM, in1, in2) of the motor DC controller and decodes them back into measured duty, direction and a fault flag.
- Samples the synchronized pins on a prescaled tick and accumulates high samples over a fixed frame.
- Reports once per frame with a one-clock valid strobe.
- Used as an on-chip self-check and as the checker end of the motor_dc bench.

Parameters:
- DIV, 1200: clk cycles per sample tick (12 MHz / 1200 = 10 kHz). Must be >= 2.
- FRAME, 256: sample ticks per measurement frame. Power of two, 16..256.

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  PWM enable pin from the H-bridge driver. Asynchronous to the tick.
- in1  input  1  bridge input 1.
- in2  input  1  bridge input 2.
- duty  output  8  high-sample count of the last frame, saturated to 255.
- dir  output  2  00 none, 01 forward (in1=1, in2=0), 10 reverse (in1=0, in2=1). 11 is never driven.
- fault  output  1  last frame contained a sample with ena=1 and in1==in2.
- duty_valid  output  1  one-clk strobe when duty, dir and fault update.
- duty_pct  output  7  duty in percent, 0..100 (see Optional Feature).

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous, active-high, and clears all flops without a clock edge.
  - Reset values: duty=0, dir=00, fault=0, duty_valid=0, duty_pct=0.
  - Synchronizers clear to 0, prescaler clears to 0, state goes to ALIGN.
- Input synchronizers: 2-flop synchronizers on ena, in1 and in2. Logic uses only the synchronized copies.
  - Latency from a pin change to the sampled value is 2 clk.
- Prescaler: counts 0..DIV-1; tick is high for one clk when the count equals DIV-1, then wraps to 0.
  - Free-running in every state except during reset.
- States:
  - ALIGN: waits for a synchronized ena rising edge, or for FRAME ticks without one, whichever comes first.
    - On edge: go to MEASURE. The tick that contains the edge cycle counts as sample 0 of the frame.
    - On timeout: go to MEASURE with the sample counter at 0.
  - MEASURE: on each tick, sample_cnt increments.
    - If ena=1, hi_cnt (9 bits, 0..256) increments.
    - If ena=1 and in1!=in2, dir_acc is set to {in2,in1}.
    - If ena=1 and in1==in2, flt_acc is set to 1.
    - On the tick where sample_cnt reaches FRAME-1, go to REPORT.
  - REPORT, one clk:
    - duty = (hi_cnt > 255) ? 255 : hi_cnt[7:0].
    - dir = dir_acc. Stays 00 if no qualifying sample occurred.
    - fault = flt_acc.
    - duty_valid = 1.
    - Clear all accumulators, then return to MEASURE. Frames are back-to-back with no re-alignment.
- Timing: consecutive duty_valid strobes are exactly DIV*FRAME clk apart. duty_valid is 0 in every other cycle.
- Outputs are registered and hold their value between reports.
- A reset asserted mid-frame discards the partial frame. The first report after release requires the full ALIGN plus one full frame.
- Boundaries:
  - ena constant high gives hi_cnt=FRAME. For FRAME=256 this saturates duty to 255.
  - A simultaneous tick and ena edge in ALIGN counts the sample.
  - A tick occurring in the REPORT cycle cannot happen, because DIV >= 2.

Optional Feature:
- Macro: HBRIDGE_DECODER_PCT_EN.
- Defined: in REPORT, duty_pct = (hi_cnt*100) / FRAME, floor. The divide is a shift because FRAME is a power of two. Registered and updated with duty_valid.
  - Examples at FRAME=256: hi_cnt 256 -> 100, 64 -> 25, 1 -> 0.
- Undefined: no multiplier is built and duty_pct is tied to 0.

Test Plan:
All scenarios use DIV=4 and FRAME=256 unless noted.
1. ena=0, in1=1, in2=0 held from reset release -> first duty_valid after the ALIGN timeout plus one frame (2048 clk), duty=0, dir=00, fault=0, duty_pct=0.
2. ena PWM with 64 of 256 samples high, in1=1, in2=0 -> duty=64, dir=01, fault=0, duty_pct=25 (macro on) / 0 (macro off).
3. ena=1 constant, in1=0, in2=1 -> duty=255 (saturated), dir=10, duty_pct=100. Next duty_valid arrives exactly 1024 clk later.
4. ena=1 with in1=in2=1 for one sample, then clean forward -> that frame reports fault=1; the following frame reports fault=0, dir=01.
5. rst pulsed mid-MEASURE with no clock edge during the pulse -> all outputs 0 immediately. No duty_valid for at least 1024 clk after release.
6. ena 50% at DIV=2, FRAME=16, in1=1, in2=0 -> duty=8, duty_pct=50, strobes every 32 clk.
